// File: rtl/decode_pkg.sv
// Shared decode types: opcodes, control encodings, immediate builder and
// the ID/EX bundle handed to execute.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_SHADD = 7'b0010000;
    localparam logic [6:0] F7_ADDUW = 7'b0000100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
        ALU_SH1ADD, ALU_SH2ADD, ALU_SH3ADD,
        ALU_ADDUW, ALU_SH1ADDUW, ALU_SH2ADDUW, ALU_SH3ADDUW,
        ALU_PASSB, ALU_AUIPC
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_src_e;

    typedef struct packed {
        logic                valid;
        logic                illegal;
        logic [XLEN_MAX-1:0] rd1;
        logic [XLEN_MAX-1:0] rd2;
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [1:0]          result_src;
        logic [4:0]          alu_ctrl;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
        logic                branch;
        logic                jump;
        logic                is_jalr;
    } id_ex_t;

    function automatic logic [63:0] imm_ext(input logic [31:7] ins,
                                            input imm_src_e src);
        logic [63:0] imm;
        unique case (src)
            IMM_I: imm = {{52{ins[31]}}, ins[31:20]};
            IMM_S: imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: imm = {{52{ins[31]}}, ins[7], ins[30:25],
                          ins[11:8], 1'b0};
            IMM_U: imm = {{32{ins[31]}}, ins[31:12], 12'b0};
            IMM_J: imm = {{44{ins[31]}}, ins[19:12], ins[20],
                          ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic alu_op_e alu_base(input logic [2:0] f3,
                                         input logic alt);
        alu_op_e op;
        unique case (f3)
            3'd0: op = alt ? ALU_SUB : ALU_ADD;
            3'd1: op = ALU_SLL;
            3'd2: op = ALU_SLT;
            3'd3: op = ALU_SLTU;
            3'd4: op = ALU_XOR;
            3'd5: op = alt ? ALU_SRA : ALU_SRL;
            3'd6: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e sh_add(input logic [2:0] f3,
                                       input logic uw);
        alu_op_e op;
        unique case (f3)
            3'd2: op = uw ? ALU_SH1ADDUW : ALU_SH1ADD;
            3'd4: op = uw ? ALU_SH2ADDUW : ALU_SH2ADD;
            default: op = uw ? ALU_SH3ADDUW : ALU_SH3ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the instruction in decode reads a register that the
// load currently in execute has not yet produced.
module hazard_detect
    import decode_pkg::*;
(
    input  logic       valid_id,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic       valid_ex,
    input  logic [1:0] result_src_ex,
    input  logic       reg_write_ex,
    input  logic [4:0] rd_ex,
    output logic       loaduse
);

    logic load_ex;
    logic hit1;
    logic hit2;

    assign load_ex = valid_ex && reg_write_ex
                  && (result_src_ex == RES_MEM) && (rd_ex != 5'd0);
    assign hit1    = use_rs1 && (rs1 == rd_ex);
    assign hit2    = use_rs2 && (rs2 == rd_ex);
    assign loaduse = valid_id && load_ex && (hit1 || hit2);

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: IF/ID register, decoder, bypassed register file, load-use
// stall and the registered ID/EX bundle with bubble/flush/hold handling.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit ZBA_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_F,
    input  logic [31:0]     Instr_F,
    input  logic [XLEN-1:0] PC_F,
    output logic            ready_F,
    input  logic            flush_D,
    input  logic            hold_E,
    input  logic [XLEN-1:0] Result_W,
    input  logic [4:0]      Rd_W,
    input  logic            RegWrite_W,
    output logic            valid_E,
    output logic            illegal_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [XLEN-1:0] PC_E,
    output logic [4:0]      Rd_E,
    output logic [4:0]      Rs1_E,
    output logic [4:0]      Rs2_E,
    output logic [1:0]      ResultSrc_E,
    output logic [4:0]      ALUControl_E,
    output logic            MemWrite_E,
    output logic            ALUSrc_E,
    output logic            RegWrite_E,
    output logic            Branch_E,
    output logic            Jump_E,
    output logic            is_jalr_E
);

    localparam bit RV64 = (XLEN == 64);

    logic            valid_D;
    logic [31:0]     Instr_D;
    logic [XLEN-1:0] PC_D;
    id_ex_t          id_ex;
    id_ex_t          dec;
    logic            loaduse;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       zba_f3;

    assign opcode = Instr_D[6:0];
    assign rd     = Instr_D[11:7];
    assign f3     = Instr_D[14:12];
    assign rs1    = Instr_D[19:15];
    assign rs2    = Instr_D[24:20];
    assign f7     = Instr_D[31:25];
    assign zba_f3 = (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);

    logic     reg_write;
    logic     mem_write;
    logic     alu_src;
    logic     branch;
    logic     jump;
    logic     is_jalr;
    logic     illegal;
    logic     use_rs1;
    logic     use_rs2;
    logic [1:0] result_src;
    alu_op_e  alu_ctrl;
    imm_src_e imm_src;

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        is_jalr    = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALU;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        unique case (opcode)
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_U;
                alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_U;
                alu_ctrl  = ALU_AUIPC;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                is_jalr    = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_PC4;
                illegal    = (f3 != 3'd0);
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                imm_src  = IMM_B;
                alu_ctrl = ALU_SUB;
                illegal  = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
                illegal    = (f3 == 3'd7) || (!RV64
                           && ((f3 == 3'd3) || (f3 == 3'd6)));
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
                illegal   = f3[2] || (!RV64 && (f3 == 3'd3));
            end
            OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = alu_base(f3, (f3 == 3'd5) && Instr_D[30]);
            end
            OP_IMM32: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                if (!RV64) illegal = 1'b1;
                else if (f3 == 3'd0) alu_ctrl = ALU_ADDW;
                else if (f3 == 3'd1 && f7 == F7_BASE) alu_ctrl = ALU_SLLW;
                else if (f3 == 3'd5 && f7 == F7_BASE) alu_ctrl = ALU_SRLW;
                else if (f3 == 3'd5 && f7 == F7_ALT) alu_ctrl = ALU_SRAW;
                else illegal = 1'b1;
            end
            OP_REG: begin
                reg_write = 1'b1;
                if (f7 == F7_BASE)
                    alu_ctrl = alu_base(f3, 1'b0);
                else if (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5))
                    alu_ctrl = alu_base(f3, 1'b1);
                else if (ZBA_EN && f7 == F7_SHADD && zba_f3)
                    alu_ctrl = sh_add(f3, 1'b0);
                else
                    illegal = 1'b1;
            end
            OP_REG32: begin
                reg_write = 1'b1;
                if (!RV64) illegal = 1'b1;
                else if (f7 == F7_BASE && f3 == 3'd0) alu_ctrl = ALU_ADDW;
                else if (f7 == F7_BASE && f3 == 3'd1) alu_ctrl = ALU_SLLW;
                else if (f7 == F7_BASE && f3 == 3'd5) alu_ctrl = ALU_SRLW;
                else if (f7 == F7_ALT && f3 == 3'd0) alu_ctrl = ALU_SUBW;
                else if (f7 == F7_ALT && f3 == 3'd5) alu_ctrl = ALU_SRAW;
                else if (ZBA_EN && f7 == F7_ADDUW && f3 == 3'd0)
                    alu_ctrl = ALU_ADDUW;
                else if (ZBA_EN && f7 == F7_SHADD && zba_f3)
                    alu_ctrl = sh_add(f3, 1'b1);
                else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // An illegal op must not change architectural state downstream.
        if (illegal) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
            is_jalr   = 1'b0;
        end
    end

    assign use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC
                    || opcode == OP_JAL);
    assign use_rs2 = (opcode == OP_REG) || (opcode == OP_REG32)
                  || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    always_ff @(posedge clk) begin
        if (RegWrite_W && Rd_W != 5'd0)
            regs[Rd_W] <= Result_W;
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0)
            rd1 = (RegWrite_W && Rd_W == rs1) ? Result_W : regs[rs1];
        if (rs2 != 5'd0)
            rd2 = (RegWrite_W && Rd_W == rs2) ? Result_W : regs[rs2];
    end

    logic [63:0] imm64;
    assign imm64 = imm_ext(Instr_D[31:7], imm_src);

    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.illegal    = illegal;
        dec.rd1        = XLEN_MAX'(rd1);
        dec.rd2        = XLEN_MAX'(rd2);
        dec.imm        = XLEN_MAX'(imm64[XLEN-1:0]);
        dec.pc         = XLEN_MAX'(PC_D);
        dec.rd         = rd;
        dec.rs1        = rs1;
        dec.rs2        = rs2;
        dec.result_src = result_src;
        dec.alu_ctrl   = alu_ctrl;
        dec.mem_write  = mem_write;
        dec.alu_src    = alu_src;
        dec.reg_write  = reg_write;
        dec.branch     = branch;
        dec.jump       = jump;
        dec.is_jalr    = is_jalr;
    end

    hazard_detect u_hazard (
        .valid_id      (valid_D),
        .rs1           (rs1),
        .rs2           (rs2),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .valid_ex      (id_ex.valid),
        .result_src_ex (id_ex.result_src),
        .reg_write_ex  (id_ex.reg_write),
        .rd_ex         (id_ex.rd),
        .loaduse       (loaduse)
    );

    assign ready_F = !rst && (flush_D || (!hold_E && !loaduse));

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_D <= 1'b0;
            Instr_D <= '0;
            PC_D    <= '0;
        end else if (flush_D) begin
            valid_D <= 1'b0;
        end else if (valid_F && ready_F) begin
            valid_D <= 1'b1;
            Instr_D <= Instr_F;
            PC_D    <= PC_F;
        end else if (!hold_E && !loaduse) begin
            valid_D <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_D) begin
            id_ex <= '0;
        end else if (!hold_E) begin
            if (loaduse || !valid_D) id_ex <= '0;
            else id_ex <= dec;
        end
    end

    assign valid_E      = id_ex.valid;
    assign illegal_E    = id_ex.illegal;
    assign RD1_E        = id_ex.rd1[XLEN-1:0];
    assign RD2_E        = id_ex.rd2[XLEN-1:0];
    assign ImmExt_E     = id_ex.imm[XLEN-1:0];
    assign PC_E         = id_ex.pc[XLEN-1:0];
    assign Rd_E         = id_ex.rd;
    assign Rs1_E        = id_ex.rs1;
    assign Rs2_E        = id_ex.rs2;
    assign ResultSrc_E  = id_ex.result_src;
    assign ALUControl_E = id_ex.alu_ctrl;
    assign MemWrite_E   = id_ex.mem_write;
    assign ALUSrc_E     = id_ex.alu_src;
    assign RegWrite_E   = id_ex.reg_write;
    assign Branch_E     = id_ex.branch;
    assign Jump_E       = id_ex.jump;
    assign is_jalr_E    = id_ex.is_jalr;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: an RV64+Zba instance and an RV32 no-Zba
// instance share the stimulus.
module tb_decode_pipe;

    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] ADDI_X4_M1 = 32'hFFF08213;
    localparam logic [31:0] LD_X2      = 32'h0000B103;
    localparam logic [31:0] ADD_321    = 32'h001101B3;
    localparam logic [31:0] ADD_311    = 32'h001081B3;
    localparam logic [31:0] ADD_650    = 32'h00028333;
    localparam logic [31:0] SH1ADD     = 32'h2020A3B3;
    localparam logic [31:0] SW_X2_8    = 32'h0020A423;
    localparam logic [31:0] BEQ_8      = 32'h00208463;
    localparam logic [31:0] JAL_16     = 32'h010000EF;
    localparam logic [31:0] BAD_OP     = 32'hFFFFFFFF;

    logic        clk;
    logic        rst;
    logic        valid_F;
    logic [31:0] Instr_F;
    logic [63:0] PC_F;
    logic        flush_D;
    logic        hold_E;
    logic [63:0] Result_W;
    logic [4:0]  Rd_W;
    logic        RegWrite_W;

    logic        ready_F, valid_E, illegal_E;
    logic [63:0] RD1_E, RD2_E, ImmExt_E, PC_E;
    logic [4:0]  Rd_E, Rs1_E, Rs2_E, ALUControl_E;
    logic [1:0]  ResultSrc_E;
    logic        MemWrite_E, ALUSrc_E, RegWrite_E;
    logic        Branch_E, Jump_E, is_jalr_E;

    logic        r32, v32, ill32;
    logic [31:0] rd1_32, rd2_32, imm32, pc32;
    logic [4:0]  rde32, rs1e32, rs2e32, alu32;
    logic [1:0]  res32;
    logic        mw32, as32, rw32, br32, j32, jr32;

    int checks = 0;
    int errors = 0;

    decode_pipe #(.XLEN(64), .ZBA_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_F(valid_F), .Instr_F(Instr_F),
        .PC_F(PC_F), .ready_F(ready_F), .flush_D(flush_D),
        .hold_E(hold_E), .Result_W(Result_W), .Rd_W(Rd_W),
        .RegWrite_W(RegWrite_W), .valid_E(valid_E),
        .illegal_E(illegal_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .ImmExt_E(ImmExt_E), .PC_E(PC_E), .Rd_E(Rd_E), .Rs1_E(Rs1_E),
        .Rs2_E(Rs2_E), .ResultSrc_E(ResultSrc_E),
        .ALUControl_E(ALUControl_E), .MemWrite_E(MemWrite_E),
        .ALUSrc_E(ALUSrc_E), .RegWrite_E(RegWrite_E),
        .Branch_E(Branch_E), .Jump_E(Jump_E), .is_jalr_E(is_jalr_E)
    );

    decode_pipe #(.XLEN(32), .ZBA_EN(1'b0)) dut32 (
        .clk(clk), .rst(rst), .valid_F(valid_F), .Instr_F(Instr_F),
        .PC_F(PC_F[31:0]), .ready_F(r32), .flush_D(flush_D),
        .hold_E(hold_E), .Result_W(Result_W[31:0]), .Rd_W(Rd_W),
        .RegWrite_W(RegWrite_W), .valid_E(v32), .illegal_E(ill32),
        .RD1_E(rd1_32), .RD2_E(rd2_32), .ImmExt_E(imm32), .PC_E(pc32),
        .Rd_E(rde32), .Rs1_E(rs1e32), .Rs2_E(rs2e32),
        .ResultSrc_E(res32), .ALUControl_E(alu32), .MemWrite_E(mw32),
        .ALUSrc_E(as32), .RegWrite_E(rw32), .Branch_E(br32),
        .Jump_E(j32), .is_jalr_E(jr32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [63:0] pc);
        valid_F = 1'b1;
        Instr_F = ins;
        PC_F    = pc;
    endtask

    task automatic idle;
        valid_F = 1'b0;
    endtask

    task automatic issue1(input logic [31:0] ins, input logic [63:0] pc);
        fetch(ins, pc);
        tick;
        idle;
        tick;
    endtask

    initial begin
        rst = 1'b1; valid_F = 1'b0; Instr_F = '0; PC_F = '0;
        flush_D = 1'b0; hold_E = 1'b0;
        Result_W = '0; Rd_W = '0; RegWrite_W = 1'b0;
        tick;
        tick;
        chk("rst_ready_low", 64'(ready_F), 0);
        rst = 1'b0;
        #1;
        chk("rst_valid_E", 64'(valid_E), 0);
        chk("rst_regwrite", 64'(RegWrite_E), 0);
        chk("rst_imm", ImmExt_E, 0);
        chk("rst_ready", 64'(ready_F), 1);

        issue1(ADDI_X1_5, 64'h0);
        chk("addi_valid", 64'(valid_E), 1);
        chk("addi_imm", ImmExt_E, 5);
        chk("addi_rw", 64'(RegWrite_E), 1);
        chk("addi_alusrc", 64'(ALUSrc_E), 1);
        chk("addi_rd", 64'(Rd_E), 1);
        chk("addi_rd1", RD1_E, 0);
        chk("addi_res", 64'(ResultSrc_E), 0);

        fetch(LD_X2, 64'h100);
        tick;
        fetch(ADD_321, 64'h104);
        tick;
        chk("ld_res", 64'(ResultSrc_E), 1);
        chk("ld_rd", 64'(Rd_E), 2);
        fetch(ADD_311, 64'h108);
        #1;
        chk("lu_ready", 64'(ready_F), 0);
        tick;
        chk("lu_bubble", 64'(valid_E), 0);
        chk("lu_bub_rw", 64'(RegWrite_E), 0);
        chk("lu_ready_back", 64'(ready_F), 1);
        tick;
        idle;
        chk("lu_add_pc", PC_E, 64'h104);
        chk("lu_add_rs1", 64'(Rs1_E), 2);
        chk("lu_add_rs2", 64'(Rs2_E), 1);
        chk("lu_add_rd", 64'(Rd_E), 3);
        chk("lu_add_alu", 64'(ALUControl_E), 0);
        tick;
        chk("lu_next_pc", PC_E, 64'h108);
        chk("lu_next_v", 64'(valid_E), 1);

        fetch(LD_X2, 64'h200);
        tick;
        fetch(ADD_311, 64'h204);
        tick;
        idle;
        chk("nolu_ready", 64'(ready_F), 1);
        tick;
        chk("nolu_pc", PC_E, 64'h204);
        chk("nolu_valid", 64'(valid_E), 1);

        fetch(ADD_650, 64'h300);
        tick;
        idle;
        RegWrite_W = 1'b1; Rd_W = 5'd5; Result_W = 64'hDEAD;
        tick;
        RegWrite_W = 1'b0;
        chk("byp_rd1", RD1_E, 64'hDEAD);
        chk("byp_rd2", RD2_E, 0);
        fetch(ADD_650, 64'h304);
        tick;
        idle;
        RegWrite_W = 1'b1; Rd_W = 5'd0; Result_W = 64'h55;
        tick;
        RegWrite_W = 1'b0;
        chk("rf_commit", RD1_E, 64'hDEAD);
        chk("rf_x0", RD2_E, 0);

        fetch(LD_X2, 64'h400);
        tick;
        fetch(ADD_321, 64'h404);
        tick;
        chk("fl_stall", 64'(ready_F), 0);
        flush_D = 1'b1;
        fetch(ADD_311, 64'h408);
        #1;
        chk("fl_ready", 64'(ready_F), 1);
        tick;
        flush_D = 1'b0;
        idle;
        chk("fl_valid_E", 64'(valid_E), 0);
        chk("fl_ready_after", 64'(ready_F), 1);
        tick;
        chk("fl_valid_D", 64'(valid_E), 0);

        fetch(ADDI_X1_5, 64'h500);
        tick;
        fetch(ADDI_X1_5, 64'h504);
        tick;
        chk("hold_pre_pc", PC_E, 64'h500);
        fetch(ADDI_X1_5, 64'h508);
        hold_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 64'(ready_F), 0);
            tick;
            chk("hold_pc", PC_E, 64'h500);
            chk("hold_valid", 64'(valid_E), 1);
        end
        hold_E = 1'b0;
        #1;
        chk("hold_release", 64'(ready_F), 1);
        tick;
        chk("hold_b", PC_E, 64'h504);
        fetch(ADDI_X1_5, 64'h50C);
        tick;
        idle;
        chk("hold_c", PC_E, 64'h508);
        tick;
        chk("hold_d", PC_E, 64'h50C);
        tick;
        chk("hold_drain", 64'(valid_E), 0);

        fetch(LD_X2, 64'h700);
        tick;
        fetch(ADD_321, 64'h704);
        tick;
        rst = 1'b1;
        idle;
        tick;
        rst = 1'b0;
        #1;
        chk("rstmid_valid", 64'(valid_E), 0);
        chk("rstmid_ready", 64'(ready_F), 1);
        tick;
        chk("rstmid_valid_D", 64'(valid_E), 0);

        issue1(LD_X2, 64'h600);
        chk("ld64_ill", 64'(illegal_E), 0);
        chk("ld64_rw", 64'(RegWrite_E), 1);
        chk("ld32_valid", 64'(v32), 1);
        chk("ld32_ill", 64'(ill32), 1);
        chk("ld32_rw", 64'(rw32), 0);
        chk("ld32_mw", 64'(mw32), 0);

        issue1(SH1ADD, 64'h604);
        chk("sh1_alu", 64'(ALUControl_E), 15);
        chk("sh1_ill", 64'(illegal_E), 0);
        chk("sh1_rw", 64'(RegWrite_E), 1);
        chk("sh1_32_ill", 64'(ill32), 1);
        chk("sh1_32_valid", 64'(v32), 1);
        chk("sh1_32_rw", 64'(rw32), 0);

        issue1(BAD_OP, 64'h608);
        chk("bad_valid", 64'(valid_E), 1);
        chk("bad_ill", 64'(illegal_E), 1);
        chk("bad_rw", 64'(RegWrite_E), 0);
        chk("bad_mw", 64'(MemWrite_E), 0);

        issue1(SW_X2_8, 64'h60C);
        chk("sw_mw", 64'(MemWrite_E), 1);
        chk("sw_rw", 64'(RegWrite_E), 0);
        chk("sw_imm", ImmExt_E, 8);
        chk("sw_rs2", 64'(Rs2_E), 2);
        chk("sw32_mw", 64'(mw32), 1);

        issue1(ADDI_X4_M1, 64'h610);
        chk("neg_imm64", ImmExt_E, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("neg_imm32", 64'(imm32), 64'hFFFF_FFFF);

        issue1(JAL_16, 64'h614);
        chk("jal_jump", 64'(Jump_E), 1);
        chk("jal_res", 64'(ResultSrc_E), 2);
        chk("jal_imm", ImmExt_E, 16);
        chk("jal_pc", PC_E, 64'h614);
        chk("jal_jalr", 64'(is_jalr_E), 0);

        issue1(BEQ_8, 64'h618);
        chk("beq_br", 64'(Branch_E), 1);
        chk("beq_imm", ImmExt_E, 8);
        chk("beq_rw", 64'(RegWrite_E), 0);
        chk("beq_alu", 64'(ALUControl_E), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised decode stage with owned pipeline registers. It holds the IF/ID register, decodes the instruction, and reads the register file with write-first bypass. It performs load-use hazard detection internally and drives a registered ID/EX bundle with bubble insertion, flush and backpressure. It sits between fetch and execute and replaces the combinational decode path plus the separate IF/ID and ID/EX registers.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- ZBA_EN, 1, 1 decodes Zba ops (sh1add/sh2add/sh3add and .uw forms); 0 makes them illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- valid_F  in  1  fetch presents an instruction.
- Instr_F  in  32  fetched instruction.
- PC_F  in  XLEN  fetched PC.
- ready_F  out  1  decode accepts this cycle; 0 means fetch must hold.
- flush_D  in  1  taken branch/jump redirect from execute.
- hold_E  in  1  execute backpressure; freezes both internal registers.
- Result_W  in  XLEN  writeback data.
- Rd_W  in  5  writeback register index.
- RegWrite_W  in  1  writeback enable.
- valid_E, illegal_E  out  1 each  ID/EX valid; illegal-instruction flag.
- RD1_E, RD2_E, ImmExt_E, PC_E  out  XLEN each  operands, extended immediate, PC.
- Rd_E, Rs1_E, Rs2_E  out  5 each  register indices.
- ResultSrc_E  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControl_E  out  5  ALU operation code.
- MemWrite_E, ALUSrc_E, RegWrite_E, Branch_E, Jump_E, is_jalr_E  out  1 each  control.

## Operation
- IF/ID register holds valid_D, Instr_D and PC_D. It loads when valid_F && ready_F.
- Decode runs combinationally on IF/ID contents and reuses the existing control and immediate encodings. Immediates are generated at 64 bits and truncated to XLEN.
- Register file:
  - x0 reads 0.
  - Write-first bypass: if RegWrite_W && Rd_W!=0 && Rd_W==rs, the read returns Result_W in the same cycle.
  - The write commits at the clk edge.
- Operand usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by R-type, OP-32, STORE and BRANCH only.
- Load-use stall:
  - Condition: valid_D && valid_E && ResultSrc_E==01 && RegWrite_E && Rd_E!=0 && Rd_E matches a used rs.
  - Response: IF/ID holds, ready_F=0, and a bubble is written into ID/EX.
- Bubble: valid_E=0, illegal_E=0, and RegWrite/MemWrite/Branch/Jump/is_jalr=0. The data fields are don't-care but are driven to 0.
- Illegal: an unknown opcode, or an RV64-only opcode (OP-32, OP-IMM-32, LD, LWU, SD, add.uw, shNadd.uw) when XLEN=32, or any Zba op when ZBA_EN=0. The instruction enters ID/EX with valid_E=1 and illegal_E=1, and all write/branch/jump enables are 0.
- Priority per edge: rst > flush_D > hold_E > load-use stall > normal advance.
  - flush_D: valid_D<=0 and valid_E<=0 regardless of valid_F or hold_E.
  - hold_E: both registers keep their contents and ready_F=0. Writeback still commits.
- ready_F = !rst && (flush_D || (!hold_E && !loaduse)).

## Timing
- Reset: all ID/EX outputs are 0 and valid_D=0, so ready_F=1 on the first cycle after reset.
- Latency: an instruction accepted at edge N appears on the *_E outputs after edge N+1.
- The load-use stall is exactly one cycle per dependent load. On the next cycle the load has left EX (valid_E reflects the bubble), so the condition clears.
- Throughput is one instruction per cycle with no hazards.
- Reset asserted mid-stall or mid-hold clears both registers. No pending state survives.
- A writeback in the same cycle as decode of a reader is seen via the bypass. No extra stall is taken.

## Structure
- Shared package (decode_pkg): opcode constants, the ResultSrc encoding, the ALUControl codes including the Zba codes, the ImmSrc type encoding, and an id_ex_t packed struct parametrised by XLEN for the ID/EX bundle.
- Reuse the existing register-file, immediate and control-unit blocks, extended for XLEN and ZBA_EN.
- One new sub-module, hazard_detect: it takes the IF/ID rs fields, usage flags and ID/EX rd/load info, and outputs loaduse.
- RTL target is about 250 lines excluding the reused blocks.

## Test plan
- Reset, then `addi x1,x0,5` at PC 0 -> after 2 edges valid_E=1, ImmExt_E=5, RegWrite_E=1, ALUSrc_E=1, Rd_E=1.
- `ld x2,0(x1)` followed by `add x3,x2,x1` -> one cycle with ready_F=0 and a bubble (valid_E=0). The add reaches EX on the next cycle, and no stall occurs for `add x3,x1,x1`.
- Writeback of x5=0xDEAD in the same cycle that `add x6,x5,x0` is in decode -> RD1_E=0xDEAD.
- flush_D together with valid_F and an active load-use stall -> next cycle valid_D=0 and valid_E=0, ready_F=1.
- hold_E for 3 cycles during a stream -> outputs frozen and ready_F=0, with no instruction lost or duplicated after release.
- XLEN=32 with `ld`, or ZBA_EN=0 with `sh1add` -> valid_E=1, illegal_E=1, RegWrite_E=0, MemWrite_E=0.
